// File: rtl/color_stabilizer.sv
// Purpose: classify edge/corner RGB samples into cube colour codes and qualify a repeatable pair after each move batch.
// Latency: class registered 1 clk after sample_valid; stable rises on the clk that consumes the qualifying class pair.
// Backpressure: none; samples outside QUALIFY are dropped, outputs frozen in HOLD until the next moves_start.
module color_stabilizer #(
  parameter logic [31:0] SETTLE_CYCLES   = 32'd500000,
  parameter int          STABLE_COUNT    = 4,
  parameter int          TIMEOUT_SAMPLES = 64,
  parameter logic [7:0]  WHITE_MIN       = 8'd200,
  parameter logic [7:0]  COLOR_MIN       = 8'd40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        moves_start,
  input  logic        motor_done,
  input  logic        sample_valid,
  input  logic [23:0] edge_rgb,
  input  logic [23:0] corner_rgb,
  output logic [2:0]  edge_color_sensor,
  output logic [2:0]  corner_color_sensor,
  output logic        color_sensor_stable,
  output logic        sensor_timeout
);

  localparam logic [2:0] CLR_W    = 3'd0;
  localparam logic [2:0] CLR_O    = 3'd1;
  localparam logic [2:0] CLR_G    = 3'd2;
  localparam logic [2:0] CLR_RED  = 3'd3;
  localparam logic [2:0] CLR_BLUE = 3'd4;
  localparam logic [2:0] CLR_Y    = 3'd5;
  localparam logic [2:0] CLR_NULL = 3'd7;

  localparam logic [31:0] SETTLE_LAST = SETTLE_CYCLES - 32'd1;
  localparam logic [15:0] STABLE_W    = 16'(STABLE_COUNT);
  localparam logic [15:0] TIMEOUT_W   = 16'(TIMEOUT_SAMPLES);

  typedef enum logic [2:0] {
    ST_IDLE, ST_BUSY, ST_SETTLE, ST_QUALIFY, ST_HOLD
  } state_t;

  // Ratio products are 11 bits wide so 8*g cannot overflow for any 8-bit g.
  function automatic logic [2:0] classify(input logic [23:0] rgb);
    logic [7:0]  r, g, b, mx;
    logic [10:0] g4, g8, r3;
    logic [2:0]  cls;
    r  = rgb[23:16];
    g  = rgb[15:8];
    b  = rgb[7:0];
    mx = r;
    if (g > mx) mx = g;
    if (b > mx) mx = b;
    g4 = {1'b0, g, 2'b00};
    g8 = {g, 3'b000};
    r3 = {3'b000, r} + {2'b00, r, 1'b0};
    if (r >= WHITE_MIN && g >= WHITE_MIN && b >= WHITE_MIN) cls = CLR_W;
    else if (mx < COLOR_MIN)                                cls = CLR_NULL;
    else if (r >= g && r >= b) begin
      if (g4 >= r3)      cls = CLR_Y;
      else if (g8 >= r3) cls = CLR_O;
      else               cls = CLR_RED;
    end
    else if (g >= b)     cls = CLR_G;
    else                 cls = CLR_BLUE;
    return cls;
  endfunction

  state_t      state_q;
  logic [2:0]  edge_cls_q, corner_cls_q, edge_cls_d, corner_cls_d;
  logic        cls_vld_q;
  logic [2:0]  cand_edge_q, cand_corner_q;
  logic [2:0]  edge_out_q, corner_out_q;
  logic        stable_q, timeout_q;
  logic [31:0] settle_q;
  logic [15:0] run_q, run_d, samp_q, samp_d;
  logic        pair_null, pair_match;

  assign edge_color_sensor   = edge_out_q;
  assign corner_color_sensor = corner_out_q;
  assign color_sensor_stable = stable_q;
  assign sensor_timeout      = timeout_q;

  // Combinational classification and next run/sample counts for the registered pair.
  always_comb begin
    edge_cls_d   = classify(edge_rgb);
    corner_cls_d = classify(corner_rgb);
    pair_null    = (edge_cls_q == CLR_NULL) || (corner_cls_q == CLR_NULL);
    pair_match   = !pair_null && (edge_cls_q == cand_edge_q) && (corner_cls_q == cand_corner_q);
    samp_d       = (samp_q == 16'hFFFF) ? samp_q : samp_q + 16'd1;
    if (pair_match) run_d = (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;
    else            run_d = pair_null ? 16'd0 : 16'd1;
  end

  // Register the class pair one clock after each sample strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      edge_cls_q   <= CLR_NULL;
      corner_cls_q <= CLR_NULL;
      cls_vld_q    <= 1'b0;
    end else begin
      cls_vld_q <= sample_valid;
      if (sample_valid) begin
        edge_cls_q   <= edge_cls_d;
        corner_cls_q <= corner_cls_d;
      end
    end
  end

  // Batch sequencing, settle timing, run qualification and the registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      settle_q      <= 32'd0;
      run_q         <= 16'd0;
      samp_q        <= 16'd0;
      cand_edge_q   <= CLR_NULL;
      cand_corner_q <= CLR_NULL;
      edge_out_q    <= CLR_NULL;
      corner_out_q  <= CLR_NULL;
      stable_q      <= 1'b0;
      timeout_q     <= 1'b0;
    end else if (moves_start) begin
      // A new batch always wins; a coincident motor_done belongs to the old batch.
      state_q   <= ST_BUSY;
      stable_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_BUSY: begin
          if (motor_done) begin
            state_q  <= ST_SETTLE;
            settle_q <= 32'd0;
          end
        end
        ST_SETTLE: begin
          if (settle_q != 32'hFFFF_FFFF) settle_q <= settle_q + 32'd1;
          if (settle_q >= SETTLE_LAST) begin
            state_q <= ST_QUALIFY;
            run_q   <= 16'd0;
            samp_q  <= 16'd0;
          end
        end
        ST_QUALIFY: begin
          if (cls_vld_q) begin
            samp_q <= samp_d;
            run_q  <= run_d;
            if (!pair_match) begin
              cand_edge_q   <= edge_cls_q;
              cand_corner_q <= corner_cls_q;
            end
            // Whenever the run qualifies the current pair equals the candidate.
            if (run_d >= STABLE_W) begin
              edge_out_q   <= edge_cls_q;
              corner_out_q <= corner_cls_q;
              stable_q     <= 1'b1;
              state_q      <= ST_HOLD;
            end else if (samp_d >= TIMEOUT_W) begin
              edge_out_q   <= edge_cls_q;
              corner_out_q <= corner_cls_q;
              stable_q     <= 1'b1;
              timeout_q    <= 1'b1;
              state_q      <= ST_HOLD;
            end
          end
        end
        ST_HOLD: ;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_color_stabilizer.sv
// Directed bench for color_stabilizer: expected qualified results queued at stimulus time,
// popped and compared when color_sensor_stable rises; exact-latency and freeze checks inline.
module tb_color_stabilizer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        moves_start = 1'b0;
  logic        motor_done = 1'b0;
  logic        sample_valid = 1'b0;
  logic [23:0] edge_rgb = 24'd0;
  logic [23:0] corner_rgb = 24'd0;
  logic [2:0]  edge_color_sensor, corner_color_sensor;
  logic        color_sensor_stable, sensor_timeout;

  typedef struct packed {
    logic [2:0] e;
    logic [2:0] c;
    logic       t;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [23:0] P_W    = {8'd220, 8'd210, 8'd205};
  localparam logic [23:0] P_BLUE = {8'd30,  8'd40,  8'd180};
  localparam logic [23:0] P_Y    = {8'd200, 8'd160, 8'd20};
  localparam logic [23:0] P_O    = {8'd200, 8'd90,  8'd20};
  localparam logic [23:0] P_RED  = {8'd200, 8'd40,  8'd20};
  localparam logic [23:0] P_G    = {8'd30,  8'd150, 8'd40};
  localparam logic [23:0] P_NULL = {8'd20,  8'd20,  8'd20};
  localparam logic [23:0] P_TIE  = {8'd100, 8'd100, 8'd100};

  logic [23:0] sw_rgb [6] = '{P_Y, P_O, P_RED, P_G, P_TIE, P_BLUE};
  logic [2:0]  sw_cls [6] = '{3'd5, 3'd1, 3'd3, 3'd2, 3'd5, 3'd4};

  color_stabilizer #(.SETTLE_CYCLES(32'd10)) dut (
    .clock               (clock),
    .reset               (reset),
    .moves_start         (moves_start),
    .motor_done          (motor_done),
    .sample_valid        (sample_valid),
    .edge_rgb            (edge_rgb),
    .corner_rgb          (corner_rgb),
    .edge_color_sensor   (edge_color_sensor),
    .corner_color_sensor (corner_color_sensor),
    .color_sensor_stable (color_sensor_stable),
    .sensor_timeout      (sensor_timeout)
  );

  always #5 clock = ~clock;

  function automatic exp_t mk(input logic [2:0] e, input logic [2:0] c, input logic t);
    exp_t x;
    x.e = e;
    x.c = c;
    x.t = t;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [23:0] e, input logic [23:0] c);
    sample_valid = 1'b1;
    edge_rgb     = e;
    corner_rgb   = c;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic pulse_start();
    moves_start = 1'b1;
    tick();
    moves_start = 1'b0;
  endtask

  task automatic pulse_done();
    motor_done = 1'b1;
    tick();
    motor_done = 1'b0;
  endtask

  task automatic start_batch();
    pulse_start();
    pulse_done();
    repeat (12) tick();
  endtask

  // Bounded wait for stable to rise, then compare against the oldest queued expectation.
  task automatic wait_stable(input string tag, input int budget);
    exp_t e;
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      if (color_sensor_stable) seen = 1'b1;
    end
    if (sb.size() > 0) e = sb.pop_front();
    else               e = mk(3'd6, 3'd6, 1'b1);
    chk({tag, "_stable"}, {7'd0, seen}, 8'd1);
    chk({tag, "_edge"}, {5'd0, edge_color_sensor}, {5'd0, e.e});
    chk({tag, "_corner"}, {5'd0, corner_color_sensor}, {5'd0, e.c});
    chk({tag, "_timeout"}, {7'd0, sensor_timeout}, {7'd0, e.t});
  endtask

  initial begin
    // Reset values while reset is held low.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_edge", {5'd0, edge_color_sensor}, 8'd7);
    chk("rst_corner", {5'd0, corner_color_sensor}, 8'd7);
    chk("rst_stable", {7'd0, color_sensor_stable}, 8'd0);
    chk("rst_timeout", {7'd0, sensor_timeout}, 8'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    tick();

    // T2: white edge / blue corner qualifies on the 4th registered pair.
    start_batch();
    sb.push_back(mk(3'd0, 3'd4, 1'b0));
    repeat (4) send(P_W, P_BLUE);
    @(negedge clock);
    chk("t2_not_yet", {7'd0, color_sensor_stable}, 8'd0);
    wait_stable("t2", 3);

    // HOLD: outputs frozen against new samples and motor_done.
    motor_done = 1'b1;
    send(P_RED, P_RED);
    motor_done = 1'b0;
    repeat (4) send(P_O, P_G);
    repeat (2) tick();
    @(negedge clock);
    chk("hold_edge", {5'd0, edge_color_sensor}, 8'd0);
    chk("hold_corner", {5'd0, corner_color_sensor}, 8'd4);
    chk("hold_stable", {7'd0, color_sensor_stable}, 8'd1);

    // T6: moves_start with coincident motor_done; a second motor_done is needed.
    moves_start = 1'b1;
    motor_done  = 1'b1;
    tick();
    moves_start = 1'b0;
    motor_done  = 1'b0;
    @(negedge clock);
    chk("t6_stable_drop", {7'd0, color_sensor_stable}, 8'd0);
    repeat (15) tick();
    repeat (4) send(P_W, P_BLUE);
    repeat (3) tick();
    @(negedge clock);
    chk("t6_still_busy", {7'd0, color_sensor_stable}, 8'd0);
    pulse_done();
    repeat (12) tick();
    sb.push_back(mk(3'd3, 3'd2, 1'b0));
    repeat (4) send(P_RED, P_G);
    wait_stable("t6", 3);

    // T5: samples during SETTLE dropped, a NULL inside a run restarts it.
    pulse_start();
    pulse_done();
    repeat (3) send(P_W, P_BLUE);
    repeat (10) tick();
    repeat (3) send(P_W, P_BLUE);
    send(P_NULL, P_BLUE);
    repeat (3) send(P_W, P_BLUE);
    tick();
    @(negedge clock);
    chk("t5_run_restart", {7'd0, color_sensor_stable}, 8'd0);
    sb.push_back(mk(3'd0, 3'd4, 1'b0));
    send(P_W, P_BLUE);
    wait_stable("t5", 3);

    // T3: classifier sweep, corner uses the next table entry.
    for (int i = 0; i < 6; i++) begin
      start_batch();
      sb.push_back(mk(sw_cls[i], sw_cls[(i + 1) % 6], 1'b0));
      repeat (4) send(sw_rgb[i], sw_rgb[(i + 1) % 6]);
      wait_stable($sformatf("t3_%0d", i), 3);
    end

    // NULL edge never qualifies; forced out on the 64th sample.
    start_batch();
    sb.push_back(mk(3'd7, 3'd2, 1'b1));
    repeat (63) send(P_NULL, P_G);
    tick();
    @(negedge clock);
    chk("null_63", {7'd0, color_sensor_stable}, 8'd0);
    send(P_NULL, P_G);
    wait_stable("null_to", 3);

    // T4: alternating Red/O edge for 64 samples -> timeout with last class (O).
    start_batch();
    sb.push_back(mk(3'd1, 3'd2, 1'b1));
    for (int i = 0; i < 63; i++) send((i % 2) ? P_O : P_RED, P_G);
    tick();
    @(negedge clock);
    chk("t4_63", {7'd0, color_sensor_stable}, 8'd0);
    send(P_O, P_G);
    wait_stable("t4", 3);

    // Qualification beats timeout when both land on the 64th sample.
    start_batch();
    sb.push_back(mk(3'd3, 3'd2, 1'b0));
    for (int i = 0; i < 60; i++) send((i % 2) ? P_O : P_RED, P_G);
    repeat (4) send(P_RED, P_G);
    wait_stable("prio", 3);

    // T1: asynchronous reset mid-QUALIFY, then IDLE after release.
    start_batch();
    repeat (2) send(P_W, P_BLUE);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk("t1_edge", {5'd0, edge_color_sensor}, 8'd7);
    chk("t1_corner", {5'd0, corner_color_sensor}, 8'd7);
    chk("t1_stable", {7'd0, color_sensor_stable}, 8'd0);
    chk("t1_timeout", {7'd0, sensor_timeout}, 8'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    pulse_done();
    repeat (12) tick();
    repeat (4) send(P_W, P_BLUE);
    repeat (3) tick();
    @(negedge clock);
    chk("t1_idle", {7'd0, color_sensor_stable}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
